// File: rtl/ctrl_decode_stage_if.sv
// ----------------------------------------------------------------------------
// ctrl_decode_stage_if
// Bundles the fetch-side handshake and the ID/EX control register outputs of
// the main-decode stage.
//   if_valid / if_instr / id_ready : fetch -> decode handshake
//   ex_flush                       : EX-stage kill of the instruction entering EX
//   ex_*                           : registered control bundle presented to EX
//   ex_md_done                     : final cycle of a MUL/DIV occupancy
// modport master : fetch/EX side (drives if_* and ex_flush)
// modport slave  : the decode stage itself
// ----------------------------------------------------------------------------
interface ctrl_decode_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_ready;
    logic        ex_flush;

    logic        ex_valid;
    logic        ex_alusrc;
    logic        ex_memtoreg;
    logic        ex_regtomem;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_mem;
    logic        ex_branch;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_opi;
    logic        ex_auipc;
    logic        ex_lui;
    logic        ex_muldiv;
    logic        ex_illegal;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        ex_md_done;

    modport master (
        output if_valid, if_instr, ex_flush,
        input  id_ready, ex_valid, ex_alusrc, ex_memtoreg, ex_regtomem, ex_regwrite,
               ex_memread, ex_memwrite, ex_mem, ex_branch, ex_jal, ex_jalr, ex_opi,
               ex_auipc, ex_lui, ex_muldiv, ex_illegal, ex_aluop, ex_rd, ex_rs1,
               ex_rs2, ex_md_done
    );

    modport slave (
        input  if_valid, if_instr, ex_flush,
        output id_ready, ex_valid, ex_alusrc, ex_memtoreg, ex_regtomem, ex_regwrite,
               ex_memread, ex_memwrite, ex_mem, ex_branch, ex_jal, ex_jalr, ex_opi,
               ex_auipc, ex_lui, ex_muldiv, ex_illegal, ex_aluop, ex_rd, ex_rs1,
               ex_rs2, ex_md_done
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ----------------------------------------------------------------------------
// ctrl_decode_stage
// Registered RV32I/M main-decode stage. Decodes the fetched instruction into
// the ID/EX control register, inserts a bubble on load-use hazards, kills the
// instruction entering EX on ex_flush, holds EX for MUL/DIV occupancy and
// flags illegal opcodes.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : ctrl_decode_stage_if.slave (fetch handshake, flush, ex_* bundle)
// Parameters:
//   ENABLE_M      : 1 decodes funct7=0000001 on OP as MUL/DIV, 0 flags it illegal
//   MULDIV_LAT    : cycles a MUL/DIV occupies EX (2..16)
//   LOADUSE_STALL : 1 enables the load-use bubble
// ----------------------------------------------------------------------------
module ctrl_decode_stage #(
    parameter bit ENABLE_M      = 1'b1,
    parameter int MULDIV_LAT    = 4,
    parameter bit LOADUSE_STALL = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    ctrl_decode_stage_if.slave  bus
);

    if (MULDIV_LAT < 2) begin : g_bad_lat
        $error("ctrl_decode_stage: MULDIV_LAT must be at least 2");
    end

    // Guarded so an illegal MULDIV_LAT still elaborates far enough to report.
    localparam int CNT_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    typedef enum logic {ST_RUN, ST_MD_BUSY} state_t;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regtomem;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       mem;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       opi;
        logic       auipc;
        logic       lui;
        logic       muldiv;
        logic       illegal;
        logic [1:0] aluop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_ctrl_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    ex_ctrl_t         ex_q, ex_d;
    logic             md_done_q, md_done_d;

    ex_ctrl_t dec;
    logic     use_rs1;
    logic     use_rs2;
    logic     hazard;

    // Instruction decode.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default infers a latch.
    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        dec.valid = 1'b1;
        dec.rd    = bus.if_instr[11:7];
        dec.rs1   = bus.if_instr[19:15];
        dec.rs2   = bus.if_instr[24:20];
        case (bus.if_instr[6:0])
            OPC_LW: begin
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                dec.memread  = 1'b1;
                dec.mem      = 1'b1;
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
            end
            OPC_SW: begin
                dec.alusrc   = 1'b1;
                dec.regtomem = 1'b1;
                dec.memwrite = 1'b1;
                dec.mem      = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OPC_BR: begin
                dec.branch   = 1'b1;
                dec.aluop    = 2'b01;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                // M-extension encoding without M support is an illegal instruction.
                if (bus.if_instr[31:25] == 7'b0000001 && !ENABLE_M) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b10;
                    dec.muldiv   = (bus.if_instr[31:25] == 7'b0000001);
                end
            end
            OPC_OPI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.opi      = 1'b1;
                use_rs1      = 1'b1;
            end
            OPC_JAL: begin
                dec.jal      = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_JALR: begin
                dec.jalr     = 1'b1;
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
            end
            OPC_AUIPC: begin
                dec.auipc    = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_LUI: begin
                dec.lui      = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // A load in EX whose destination is read by the incoming instruction.
    // x0 is never a real dependency.
    assign hazard = LOADUSE_STALL && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    bus.if_valid &&
                    ((use_rs1 && (dec.rs1 == ex_q.rd)) || (use_rs2 && (dec.rs2 == ex_q.rd)));

    assign bus.id_ready = !reset && (state_q == ST_RUN) && !hazard && !bus.ex_flush;

    // EX-register next state, highest priority first: flush, MUL/DIV hold,
    // hazard bubble, accept, idle bubble.
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        ex_d      = ex_q;
        md_done_d = 1'b0;
        if (bus.ex_flush) begin
            ex_d     = '0;
            state_d  = ST_RUN;
            md_cnt_d = '0;
        end else if (state_q == ST_MD_BUSY) begin
            // md_cnt counts the hold cycles left before the done cycle.
            if (md_cnt_q == '0) begin
                md_done_d = 1'b1;
                state_d   = ST_RUN;
            end else begin
                md_cnt_d = md_cnt_q - 1'b1;
            end
        end else if (hazard) begin
            ex_d = '0;
        end else if (bus.if_valid) begin
            ex_d = dec;
            if (dec.muldiv) begin
                state_d  = ST_MD_BUSY;
                md_cnt_d = CNT_W'(MULDIV_LAT - 2);
            end
        end else begin
            ex_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            md_cnt_q  <= '0;
            ex_q      <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            ex_q      <= ex_d;
            md_done_q <= md_done_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_memtoreg = ex_q.memtoreg;
    assign bus.ex_regtomem = ex_q.regtomem;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_memwrite = ex_q.memwrite;
    assign bus.ex_mem      = ex_q.mem;
    assign bus.ex_branch   = ex_q.branch;
    assign bus.ex_jal      = ex_q.jal;
    assign bus.ex_jalr     = ex_q.jalr;
    assign bus.ex_opi      = ex_q.opi;
    assign bus.ex_auipc    = ex_q.auipc;
    assign bus.ex_lui      = ex_q.lui;
    assign bus.ex_muldiv   = ex_q.muldiv;
    assign bus.ex_illegal  = ex_q.illegal;
    assign bus.ex_aluop    = ex_q.aluop;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_md_done  = md_done_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_ctrl_decode_stage
// Two instances share one stimulus stream:
//   dut0: ENABLE_M=1, MULDIV_LAT=4,  LOADUSE_STALL=1
//   dut1: ENABLE_M=0, MULDIV_LAT=16, LOADUSE_STALL=0
// A cycle-level reference model pushes the expected id_ready and the expected
// next-cycle EX bundle into queues; independent monitors pop and compare.
// ----------------------------------------------------------------------------
module tb_ctrl_decode_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_decode_stage_if u_if0 ();
    ctrl_decode_stage_if u_if1 ();

    ctrl_decode_stage #(.ENABLE_M(1'b1), .MULDIV_LAT(4), .LOADUSE_STALL(1'b1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if0.slave)
    );

    ctrl_decode_stage #(.ENABLE_M(1'b0), .MULDIV_LAT(16), .LOADUSE_STALL(1'b0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if1.slave)
    );

    typedef struct packed {
        logic       valid, alusrc, memtoreg, regtomem, regwrite, memread, memwrite, mem;
        logic       branch, jal, jalr, opi, auipc, lui, muldiv, illegal;
        logic [1:0] aluop;
        logic [4:0] rd, rs1, rs2;
        logic       md_done;
    } exp_t;

    exp_t act0, act1;
    assign act0 = {u_if0.ex_valid, u_if0.ex_alusrc, u_if0.ex_memtoreg, u_if0.ex_regtomem,
                   u_if0.ex_regwrite, u_if0.ex_memread, u_if0.ex_memwrite, u_if0.ex_mem,
                   u_if0.ex_branch, u_if0.ex_jal, u_if0.ex_jalr, u_if0.ex_opi,
                   u_if0.ex_auipc, u_if0.ex_lui, u_if0.ex_muldiv, u_if0.ex_illegal,
                   u_if0.ex_aluop, u_if0.ex_rd, u_if0.ex_rs1, u_if0.ex_rs2, u_if0.ex_md_done};
    assign act1 = {u_if1.ex_valid, u_if1.ex_alusrc, u_if1.ex_memtoreg, u_if1.ex_regtomem,
                   u_if1.ex_regwrite, u_if1.ex_memread, u_if1.ex_memwrite, u_if1.ex_mem,
                   u_if1.ex_branch, u_if1.ex_jal, u_if1.ex_jalr, u_if1.ex_opi,
                   u_if1.ex_auipc, u_if1.ex_lui, u_if1.ex_muldiv, u_if1.ex_illegal,
                   u_if1.ex_aluop, u_if1.ex_rd, u_if1.ex_rs1, u_if1.ex_rs2, u_if1.ex_md_done};

    int checks = 0;
    int errors = 0;

    exp_t q_ex0[$];
    exp_t q_ex1[$];
    logic q_rdy0[$];
    logic q_rdy1[$];

    // Reference model state: what EX holds and how many more cycles it stays.
    exp_t m_ex[2];
    int   m_busy[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic reads_rs1(input logic [6:0] opc);
        return opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return opc inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic exp_t decode(input logic [31:0] ins, input logic en_m);
        exp_t e;
        e       = '0;
        e.valid = 1'b1;
        e.rd    = ins[11:7];
        e.rs1   = ins[19:15];
        e.rs2   = ins[24:20];
        case (ins[6:0])
            7'h03: begin e.alusrc = 1; e.memtoreg = 1; e.memread = 1; e.mem = 1; e.regwrite = 1; end
            7'h23: begin e.alusrc = 1; e.regtomem = 1; e.memwrite = 1; e.mem = 1; end
            7'h63: begin e.branch = 1; e.aluop = 2'b01; end
            7'h33: begin
                if (ins[31:25] == 7'h01 && !en_m) e.illegal = 1;
                else begin
                    e.regwrite = 1;
                    e.aluop    = 2'b10;
                    e.muldiv   = (ins[31:25] == 7'h01);
                end
            end
            7'h13: begin e.alusrc = 1; e.regwrite = 1; e.opi = 1; end
            7'h6F: begin e.jal = 1; e.regwrite = 1; end
            7'h67: begin e.jalr = 1; e.regwrite = 1; end
            7'h17: begin e.auipc = 1; e.regwrite = 1; end
            7'h37: begin e.lui = 1; e.regwrite = 1; end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    // Apply one cycle of inputs to both DUTs, advance both models, queue the
    // expectations, then move to the next drive point (posedge + 2).
    task automatic drive(input logic rst, input logic v, input logic [31:0] ins, input logic fl);
        exp_t  cur, nxt;
        int    b, lat;
        logic  en_m, lu, haz, rdy;
        reset          = rst;
        u_if0.if_valid = v;   u_if1.if_valid = v;
        u_if0.if_instr = ins; u_if1.if_instr = ins;
        u_if0.ex_flush = fl;  u_if1.ex_flush = fl;
        for (int d = 0; d < 2; d++) begin
            en_m = (d == 0);
            lu   = (d == 0);
            lat  = (d == 0) ? 4 : 16;
            cur  = m_ex[d];
            b    = m_busy[d];
            haz  = lu && cur.valid && cur.memread && (cur.rd != 0) && v &&
                   ((reads_rs1(ins[6:0]) && ins[19:15] == cur.rd) ||
                    (reads_rs2(ins[6:0]) && ins[24:20] == cur.rd));
            rdy  = !rst && (b == 0) && !haz && !fl;
            if (rst || fl) begin
                nxt = '0;
                b   = 0;
            end else if (b > 0) begin
                nxt         = cur;
                b           = b - 1;
                nxt.md_done = (b == 0);
            end else if (haz || !v) begin
                nxt = '0;
            end else begin
                nxt = decode(ins, en_m);
                if (nxt.muldiv) b = lat - 1;
            end
            m_ex[d]   = nxt;
            m_busy[d] = b;
            if (d == 0) begin q_rdy0.push_back(rdy); q_ex0.push_back(nxt); end
            else        begin q_rdy1.push_back(rdy); q_ex1.push_back(nxt); end
        end
        @(posedge clk);
        #2;
    endtask

    // EX-register monitor: one expected bundle per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_ex0.size() > 0) check("ex_bundle_dut0", 64'(act0), 64'(q_ex0.pop_front()));
            if (q_ex1.size() > 0) check("ex_bundle_dut1", 64'(act1), 64'(q_ex1.pop_front()));
        end
    end

    // Handshake monitor: id_ready sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q_rdy0.size() > 0) check("id_ready_dut0", 64'(u_if0.id_ready), 64'(q_rdy0.pop_front()));
            if (q_rdy1.size() > 0) check("id_ready_dut1", 64'(u_if1.id_ready), 64'(q_rdy1.pop_front()));
        end
    end

    localparam logic [31:0] I_ADDI  = 32'h00500093; // ADDI x1,x0,5
    localparam logic [31:0] I_LW5   = 32'h00012283; // LW   x5,0(x2)
    localparam logic [31:0] I_ADD   = 32'h00728333; // ADD  x6,x5,x7
    localparam logic [31:0] I_LW0   = 32'h00012003; // LW   x0,0(x2)
    localparam logic [31:0] I_ADDX0 = 32'h00700333; // ADD  x6,x0,x7
    localparam logic [31:0] I_MUL   = 32'h022081B3; // MUL  x3,x1,x2
    localparam logic [31:0] I_BEQ   = 32'h00208063; // BEQ  x1,x2,0
    localparam logic [31:0] I_JALR  = 32'h000280E7; // JALR x1,0(x5)
    localparam logic [31:0] I_BAD   = 32'h0000007F; // reserved opcode

    logic [6:0] opc_tab [10] = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13,
                                 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F};
    logic [6:0] f7_tab  [3]  = '{7'h00, 7'h20, 7'h01};

    initial begin
        m_ex[0] = '0; m_ex[1] = '0;
        m_busy[0] = 0; m_busy[1] = 0;
        u_if0.if_valid = 1'b0; u_if1.if_valid = 1'b0;
        u_if0.if_instr = '0;   u_if1.if_instr = '0;
        u_if0.ex_flush = 1'b0; u_if1.ex_flush = 1'b0;
        @(posedge clk);
        #2;

        repeat (3) drive(1, 0, 32'h0, 0);
        // ADDI, then load-use pair (ADD held while stalled), then x0 load.
        drive(0, 1, I_ADDI, 0);
        drive(0, 1, I_LW5, 0);
        drive(0, 1, I_ADD, 0);
        drive(0, 1, I_ADD, 0);
        drive(0, 1, I_LW0, 0);
        drive(0, 1, I_ADDX0, 0);
        drive(0, 1, I_LW5, 0);
        drive(0, 1, I_LW5, 0);   // dependent load: rs1=x2, no stall
        drive(0, 0, 32'h0, 0);
        // MUL occupancy, then back-to-back MULs held at fetch.
        drive(0, 1, I_MUL, 0);
        repeat (4) drive(0, 1, I_ADDI, 0);
        repeat (6) drive(0, 1, I_MUL, 0);
        repeat (4) drive(0, 0, 32'h0, 0);
        // Flush with BEQ presented, then flush in MUL occupancy cycle 2.
        drive(0, 1, I_BEQ, 1);
        drive(0, 1, I_ADDI, 0);
        drive(0, 1, I_MUL, 0);
        drive(0, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 1);
        drive(0, 1, I_ADDI, 0);
        drive(0, 0, 32'h0, 0);
        // JALR and a reserved opcode.
        drive(0, 1, I_JALR, 0);
        drive(0, 1, I_BAD, 0);
        // Reset during MUL occupancy, and reset coinciding with a hazard.
        drive(0, 1, I_MUL, 0);
        drive(0, 0, 32'h0, 0);
        drive(1, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        drive(0, 1, I_LW5, 0);
        drive(1, 1, I_ADD, 0);
        drive(0, 0, 32'h0, 0);

        // Randomised traffic over a small register set to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ins;
            logic        rst, v, fl;
            ins = {f7_tab[$urandom_range(0, 2)], 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 3'($urandom), 5'($urandom_range(0, 3)),
                   opc_tab[$urandom_range(0, 9)]};
            rst = ($urandom_range(0, 49) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            v   = ($urandom_range(0, 3) != 0);
            drive(rst, v, ins, fl);
        end

        repeat (2) drive(0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
